// File: rtl/dmem_bridge.sv
// Bridge from the execute stage's 64-bit load/store request to a 32-bit request/response bus.
// Issues one or two bus beats and returns the extended load result, stalling the core meanwhile.
module dmem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              stall,
    output logic [63:0]       rdata,
    output logic              err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LO_REQ, LO_RSP, HI_REQ, HI_RSP, DONE} state_t;

    state_t           state;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             uns_q;
    logic             we_q;
    logic [31:0]      whi_q;
    logic [31:0]      lo_word;
    logic [CNT_W-1:0] tcnt;

    logic             misaligned;
    logic [31:0]      lane_wdata;
    logic [3:0]       lane_wstrb;
    logic [31:0]      shifted;
    logic [63:0]      load_ext;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^req_addr[63:ADDR_W];

    assign stall = (state == LO_REQ) || (state == LO_RSP) || (state == HI_REQ) ||
                   (state == HI_RSP) || ((state == IDLE) && (req_read || req_write));

    always_comb begin
        misaligned = 1'b0;
        lane_wdata = req_wdata[31:0];
        lane_wstrb = 4'hF;
        case (req_size)
            2'd0: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                misaligned = req_addr[0];
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wstrb = 4'b0011 << req_addr[1:0];
            end
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // The final beat's data is extended straight off the bus so DONE can present it at once.
    always_comb begin
        shifted  = bus_rdata >> {off_q, 3'b000};
        load_ext = {bus_rdata, lo_word};
        case (size_q)
            2'd0: load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_ext = uns_q ? {32'd0, bus_rdata}     : {{32{bus_rdata[31]}}, bus_rdata};
            default: load_ext = {bus_rdata, lo_word};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            size_q        <= 2'd0;
            off_q         <= 2'd0;
            uns_q         <= 1'b0;
            we_q          <= 1'b0;
            whi_q         <= 32'd0;
            lo_word       <= 32'd0;
            tcnt          <= '0;
            rdata         <= 64'd0;
            err           <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= 32'd0;
            bus_wstrb     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_write || req_read) begin
                        size_q <= req_size;
                        off_q  <= req_addr[1:0];
                        uns_q  <= req_unsigned;
                        we_q   <= req_write;
                        whi_q  <= req_wdata[63:32];
                        rdata  <= 64'd0;
                        err    <= 1'b0;
                        if (misaligned) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end else begin
                            state         <= LO_REQ;
                            bus_req_valid <= 1'b1;
                            bus_we        <= req_write;
                            bus_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
                            bus_wdata     <= lane_wdata;
                            bus_wstrb     <= req_write ? lane_wstrb : 4'h0;
                        end
                    end
                end
                LO_REQ, HI_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        tcnt          <= '0;
                        state         <= (state == LO_REQ) ? LO_RSP : HI_RSP;
                    end
                end
                LO_RSP, HI_RSP: begin
                    if (bus_rsp_valid) begin
                        if (!we_q) lo_word <= bus_rdata;
                        if ((state == LO_RSP) && (size_q == 2'd3)) begin
                            state         <= HI_REQ;
                            bus_req_valid <= 1'b1;
                            bus_addr      <= bus_addr + ADDR_W'(4);
                            bus_wdata     <= whi_q;
                        end else begin
                            state <= DONE;
                            rdata <= we_q ? 64'd0 : load_ext;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (tcnt == CNT_LAST) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a small bus responder plus one task per scenario.
`timescale 1ns/1ps
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        stall, err;
    logic [63:0] rdata;
    logic        bus_req_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_req_ready, bus_rsp_valid;

    int checks = 0;
    int errors = 0;

    // Responder controls: automatic mode, or manual drive by a test.
    logic        auto_bus = 1'b1;
    logic        auto_ready = 1'b0, auto_rsp = 1'b0;
    logic [31:0] auto_rdata = 32'd0;
    logic        man_ready = 1'b0, man_rsp = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    int          rdy_wait = 0;
    logic        rsp_en = 1'b1;
    logic [31:0] resp_lo = 32'd0, resp_hi = 32'd0;

    int          wait_cnt = 0;
    int          rsp_idx = 0;
    logic        rsp_pending = 1'b0;
    int          beat_total = 0;
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata[64];
    logic [3:0]  log_wstrb[64];
    logic        log_we   [64];

    assign bus_req_ready = auto_bus ? auto_ready : man_ready;
    assign bus_rsp_valid = auto_bus ? auto_rsp   : man_rsp;
    assign bus_rdata     = auto_bus ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    dmem_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .err(err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    // Bus responder: decides ready/response for the next rising edge and logs accepted beats.
    always @(negedge clk) begin
        if (rsp_pending && rsp_en) begin
            auto_rsp    = 1'b1;
            auto_rdata  = (rsp_idx == 0) ? resp_lo : resp_hi;
            rsp_idx     = rsp_idx + 1;
            rsp_pending = 1'b0;
        end else begin
            auto_rsp = 1'b0;
        end
        if (stall === 1'b0) begin
            rsp_idx     = 0;
            rsp_pending = 1'b0;
        end
        if (auto_bus && bus_req_valid === 1'b1) begin
            if (wait_cnt >= rdy_wait) begin
                auto_ready = 1'b1;
                log_addr [beat_total % 64] = bus_addr;
                log_wdata[beat_total % 64] = bus_wdata;
                log_wstrb[beat_total % 64] = bus_wstrb;
                log_we   [beat_total % 64] = bus_we;
                beat_total  = beat_total + 1;
                rsp_pending = 1'b1;
                wait_cnt    = 0;
            end else begin
                auto_ready = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            auto_ready = 1'b0;
        end
    end

    // Presents one request, holds it while stalled, and returns what DONE showed.
    task automatic do_access(input logic wr, input logic rd, input logic [1:0] size,
                             input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                             output int scnt, output logic [63:0] got_rdata, output logic got_err);
        @(negedge clk);
        req_write = wr; req_read = rd; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        #1;
        scnt = 0;
        while (stall === 1'b1 && scnt < 400) begin
            scnt++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (scnt >= 400) begin
            errors++;
            $display("[TB] FAIL access_bound stall still %b after %0d cycles, required 0", stall, scnt);
        end
        got_rdata = rdata;
        got_err   = err;
        req_read  = 1'b0;
        req_write = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_req_valid, bus_we, bus_wstrb, err, stall} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b required 00000000",
                     {bus_req_valid, bus_we, bus_wstrb, err, stall});
        end
        checks++;
        if ({bus_addr, bus_wdata, rdata} !== 128'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h %h %h required zeros", bus_addr, bus_wdata, rdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_word;
        int sc; logic [63:0] rd; logic e; int base;
        base = beat_total;
        resp_lo = 32'h8000_0001;
        do_access(1'b0, 1'b1, 2'd2, 1'b0, 64'h1004, 64'd0, sc, rd, e);
        checks++;
        if (sc != 3) begin errors++; $display("[TB] FAIL lw_stall got %0d required 3", sc); end
        checks++;
        if (rd !== 64'hFFFF_FFFF_8000_0001 || e !== 1'b0) begin
            errors++; $display("[TB] FAIL lw_rdata got %h err %b required ffffffff80000001 err 0", rd, e);
        end
        checks++;
        if (beat_total - base != 1 || log_addr[base % 64] !== 32'h1004 ||
            log_wstrb[base % 64] !== 4'h0 || log_we[base % 64] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_beat got n=%0d addr %h strb %h we %b required n=1 addr 00001004 strb 0 we 0",
                     beat_total - base, log_addr[base % 64], log_wstrb[base % 64], log_we[base % 64]);
        end
        do_access(1'b0, 1'b1, 2'd2, 1'b1, 64'h1004, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'h0000_0000_8000_0001) begin
            errors++; $display("[TB] FAIL lwu_rdata got %h required 0000000080000001", rd);
        end
    endtask

    task automatic test_load_byte_half;
        int sc; logic [63:0] rd; logic e;
        resp_lo = 32'hAB00_0000;
        do_access(1'b0, 1'b1, 2'd0, 1'b1, 64'h2003, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'h0000_0000_0000_00AB) begin
            errors++; $display("[TB] FAIL lbu_rdata got %h required 00000000000000ab", rd);
        end
        do_access(1'b0, 1'b1, 2'd0, 1'b0, 64'h2003, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_FFAB) begin
            errors++; $display("[TB] FAIL lb_rdata got %h required ffffffffffffffab", rd);
        end
        resp_lo = 32'h8001_7F00;
        do_access(1'b0, 1'b1, 2'd1, 1'b0, 64'h5002, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'hFFFF_FFFF_FFFF_8001) begin
            errors++; $display("[TB] FAIL lh_hi_rdata got %h required ffffffffffff8001", rd);
        end
        do_access(1'b0, 1'b1, 2'd1, 1'b0, 64'h5000, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'h0000_0000_0000_7F00) begin
            errors++; $display("[TB] FAIL lh_lo_rdata got %h required 0000000000007f00", rd);
        end
    endtask

    task automatic test_load_double;
        int sc; logic [63:0] rd; logic e; int base;
        base = beat_total;
        resp_lo = 32'h89AB_CDEF;
        resp_hi = 32'h0123_4567;
        do_access(1'b0, 1'b1, 2'd3, 1'b0, 64'h6000, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'h0123_4567_89AB_CDEF || sc != 5) begin
            errors++; $display("[TB] FAIL ld_rdata got %h stall %0d required 0123456789abcdef stall 5", rd, sc);
        end
        checks++;
        if (beat_total - base != 2 || log_addr[(base + 1) % 64] !== 32'h6004) begin
            errors++; $display("[TB] FAIL ld_beats got n=%0d hi addr %h required n=2 hi addr 00006004",
                               beat_total - base, log_addr[(base + 1) % 64]);
        end
    endtask

    task automatic test_store_double_wait;
        int sc; logic [63:0] rd; logic e; int base;
        base = beat_total;
        rdy_wait = 2;
        do_access(1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'h1122_3344_5566_7788, sc, rd, e);
        rdy_wait = 0;
        checks++;
        if (sc != 9 || rd !== 64'd0 || e !== 1'b0) begin
            errors++; $display("[TB] FAIL sd_done got stall %0d rdata %h err %b required stall 9 rdata 0 err 0", sc, rd, e);
        end
        checks++;
        if (beat_total - base != 2 ||
            log_addr[base % 64] !== 32'h3000 || log_wdata[base % 64] !== 32'h5566_7788 ||
            log_wstrb[base % 64] !== 4'hF || log_we[base % 64] !== 1'b1) begin
            errors++; $display("[TB] FAIL sd_lo_beat got n=%0d %h %h %h required n=2 00003000 55667788 f",
                               beat_total - base, log_addr[base % 64], log_wdata[base % 64], log_wstrb[base % 64]);
        end
        checks++;
        if (log_addr[(base + 1) % 64] !== 32'h3004 || log_wdata[(base + 1) % 64] !== 32'h1122_3344 ||
            log_wstrb[(base + 1) % 64] !== 4'hF || log_we[(base + 1) % 64] !== 1'b1) begin
            errors++; $display("[TB] FAIL sd_hi_beat got %h %h %h required 00003004 11223344 f",
                               log_addr[(base + 1) % 64], log_wdata[(base + 1) % 64], log_wstrb[(base + 1) % 64]);
        end
    endtask

    task automatic test_store_lanes;
        int sc; logic [63:0] rd; logic e; int base;
        base = beat_total;
        do_access(1'b1, 1'b0, 2'd0, 1'b0, 64'h7002, 64'h0000_0000_0000_125A, sc, rd, e);
        checks++;
        if (log_addr[base % 64] !== 32'h7000 || log_wdata[base % 64] !== 32'h5A5A_5A5A ||
            log_wstrb[base % 64] !== 4'b0100) begin
            errors++; $display("[TB] FAIL sb_lane got %h %h %b required 00007000 5a5a5a5a 0100",
                               log_addr[base % 64], log_wdata[base % 64], log_wstrb[base % 64]);
        end
        do_access(1'b1, 1'b0, 2'd1, 1'b0, 64'h7002, 64'h0000_0000_00AA_BEEF, sc, rd, e);
        checks++;
        if (log_wdata[(base + 1) % 64] !== 32'hBEEF_BEEF || log_wstrb[(base + 1) % 64] !== 4'b1100) begin
            errors++; $display("[TB] FAIL sh_lane got %h %b required beefbeef 1100",
                               log_wdata[(base + 1) % 64], log_wstrb[(base + 1) % 64]);
        end
        // Write wins over read, and upper address bits are dropped.
        do_access(1'b1, 1'b1, 2'd2, 1'b0, 64'hFFFF_FFFF_0000_1008, 64'h0000_0000_CAFE_F00D, sc, rd, e);
        checks++;
        if (log_we[(base + 2) % 64] !== 1'b1 || log_addr[(base + 2) % 64] !== 32'h1008 ||
            log_wdata[(base + 2) % 64] !== 32'hCAFE_F00D || rd !== 64'd0) begin
            errors++; $display("[TB] FAIL sw_prio got we %b addr %h data %h rdata %h required 1 00001008 cafef00d 0",
                               log_we[(base + 2) % 64], log_addr[(base + 2) % 64], log_wdata[(base + 2) % 64], rd);
        end
    endtask

    task automatic test_misaligned;
        int sc; logic [63:0] rd; logic e; int base;
        base = beat_total;
        do_access(1'b1, 1'b0, 2'd1, 1'b0, 64'h4001, 64'h1234, sc, rd, e);
        checks++;
        if (sc != 1 || e !== 1'b1 || beat_total != base || rd !== 64'd0) begin
            errors++; $display("[TB] FAIL sh_misaligned got stall %0d err %b beats %0d rdata %h required 1 1 0 0",
                               sc, e, beat_total - base, rd);
        end
        do_access(1'b0, 1'b1, 2'd2, 1'b0, 64'h1002, 64'd0, sc, rd, e);
        checks++;
        if (e !== 1'b1 || beat_total != base) begin
            errors++; $display("[TB] FAIL lw_misaligned got err %b beats %0d required 1 0", e, beat_total - base);
        end
        do_access(1'b0, 1'b1, 2'd3, 1'b0, 64'h6004, 64'd0, sc, rd, e);
        checks++;
        if (e !== 1'b1 || beat_total != base) begin
            errors++; $display("[TB] FAIL ld_misaligned got err %b beats %0d required 1 0", e, beat_total - base);
        end
    endtask

    task automatic test_timeout;
        int sc; logic [63:0] rd; logic e; int base;
        base = beat_total;
        rsp_en = 1'b0;
        do_access(1'b0, 1'b1, 2'd3, 1'b0, 64'h9000, 64'd0, sc, rd, e);
        rsp_en = 1'b1;
        checks++;
        if (sc != 6 || e !== 1'b1 || rd !== 64'd0) begin
            errors++; $display("[TB] FAIL ld_timeout got stall %0d err %b rdata %h required 6 1 0", sc, e, rd);
        end
        checks++;
        if (beat_total - base != 1) begin
            errors++; $display("[TB] FAIL timeout_no_hi got beats %0d required 1", beat_total - base);
        end
    endtask

    task automatic test_reset_mid_access;
        int sc; logic [63:0] rd; logic e;
        auto_bus = 1'b0;
        @(negedge clk);
        req_read = 1'b1; req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h8000; man_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        man_rsp = 1'b1; man_rdata = 32'h1111_2222;
        @(negedge clk);
        man_rsp = 1'b0;
        #1;
        checks++;
        if (bus_req_valid !== 1'b1 || bus_addr !== 32'h8004) begin
            errors++; $display("[TB] FAIL hi_req got valid %b addr %h required 1 00008004", bus_req_valid, bus_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_req_valid, bus_we, bus_wstrb, err} !== 7'd0 || {bus_addr, bus_wdata, rdata} !== 128'd0) begin
            errors++; $display("[TB] FAIL reset_mid got valid %b addr %h rdata %h err %b required all zero",
                               bus_req_valid, bus_addr, rdata, err);
        end
        req_read = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_stall got %b required 0", stall);
        end
        @(negedge clk);
        reset = 1'b0;
        man_rsp = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        man_rsp = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || bus_req_valid !== 1'b0 || rdata !== 64'd0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL stale_rsp got stall %b valid %b rdata %h err %b required 0 0 0 0",
                               stall, bus_req_valid, rdata, err);
        end
        man_ready = 1'b0;
        auto_bus  = 1'b1;
        resp_lo   = 32'h0000_7123;
        do_access(1'b0, 1'b1, 2'd2, 1'b0, 64'h1004, 64'd0, sc, rd, e);
        checks++;
        if (rd !== 64'h0000_0000_0000_7123 || e !== 1'b0 || sc != 3) begin
            errors++; $display("[TB] FAIL post_reset_lw got %h err %b stall %0d required 7123 0 3", rd, e, sc);
        end
    endtask

    initial begin
        req_read = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0;
        test_reset;
        test_load_word;
        test_load_byte_half;
        test_load_double;
        test_store_double_wait;
        test_store_lanes;
        test_misaligned;
        test_timeout;
        test_reset_mid_access;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout sim time exceeded, required completion");
        $fatal(1, "[TB] stopped");
    end

endmodule
